multiplier_datapath: RTL and testbench

Register-and-arithmetic datapath for the 8-bit signed shift-add multiplier. It executes the Clr_Ld / Add / Sub / Shift strobes issued by the multiplier control FSM and returns the current multiplier LSB (M) for the next decision. It also tracks shift count, completion and protocol misuse. It holds the 17-bit product chain X:A:B and feeds Aval/Bval to the hex display drivers.

---
 rtl/multiplier_datapath.sv | 130 +++++++++++++
 tb/tb_multiplier_datapath.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multiplier_datapath.sv
// Register/arithmetic datapath for the 8-bit signed shift-add multiplier.
// Executes one control strobe per cycle on the X:A:B chain and flags protocol misuse.
module multiplier_datapath (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Clr_Ld,
  input  logic       Add,
  input  logic       Sub,
  input  logic       Shift,
  input  logic [7:0] S,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       X,
  output logic       M,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_ADD,
    OP_SUB,
    OP_SHIFT,
    OP_ILLEGAL
  } op_e;

  logic signed [7:0] a_p0, a_nx;
  logic signed [7:0] b_p0, b_nx;
  logic              x_p0, x_nx;
  logic        [3:0] step_p0, step_nx;
  logic              done_p0, done_nx;
  logic              err_p0, err_nx;

  op_e               op;
  logic              multi_strobe;
  logic        [8:0] sum9;

  // 9-bit sign-extended add/subtract; bit 8 becomes the new X.
  function automatic logic [8:0] addsub9(input logic signed [7:0] a,
                                         input logic signed [7:0] s,
                                         input logic              sub);
    logic signed [8:0] ae;
    logic signed [8:0] se;
    ae = {a[7], a};
    se = {s[7], s};
    return sub ? 9'(ae - se) : 9'(ae + se);
  endfunction

  assign multi_strobe = (Clr_Ld & (Add | Sub | Shift)) |
                        (Add & (Sub | Shift)) |
                        (Sub & Shift);

  always_comb begin
    op = OP_HOLD;
    if (multi_strobe)
      op = OP_ILLEGAL;
    else if (Clr_Ld)
      op = OP_CLR;
    else if ((Add | Sub | Shift) && done_p0)
      op = OP_ILLEGAL;
    else if (Add)
      op = OP_ADD;
    else if (Sub)
      op = OP_SUB;
    else if (Shift)
      op = OP_SHIFT;
  end

  assign sum9 = addsub9(a_p0, S, (op == OP_SUB));

  always_comb begin
    a_nx    = a_p0;
    b_nx    = b_p0;
    x_nx    = x_p0;
    step_nx = step_p0;
    done_nx = done_p0;
    err_nx  = err_p0;
    case (op)
      OP_CLR: begin
        a_nx    = '0;
        b_nx    = S;
        x_nx    = 1'b0;
        step_nx = 4'd0;
        done_nx = 1'b0;
        err_nx  = 1'b0;
      end
      OP_ADD, OP_SUB: begin
        a_nx = sum9[7:0];
        x_nx = sum9[8];
      end
      OP_SHIFT: begin
        // X stays put so it keeps feeding the sign into A on every shift.
        a_nx    = {x_p0, a_p0[7:1]};
        b_nx    = {a_p0[0], b_p0[7:1]};
        step_nx = step_p0 + 4'd1;
        done_nx = (step_nx == 4'd8);
      end
      OP_ILLEGAL: err_nx = 1'b1;
      default: ;
    endcase
  end

  // State register stage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_p0    <= '0;
      b_p0    <= '0;
      x_p0    <= 1'b0;
      step_p0 <= 4'd0;
      done_p0 <= 1'b0;
      err_p0  <= 1'b0;
    end else begin
      a_p0    <= a_nx;
      b_p0    <= b_nx;
      x_p0    <= x_nx;
      step_p0 <= step_nx;
      done_p0 <= done_nx;
      err_p0  <= err_nx;
    end
  end

  assign Aval = a_p0;
  assign Bval = b_p0;
  assign X    = x_p0;
  assign M    = b_p0[0];
  assign Done = done_p0;
  assign Err  = err_p0;

endmodule

// File: tb/tb_multiplier_datapath.sv
// Randomized self-checking bench for multiplier_datapath against an integer reference model.
module tb_multiplier_datapath;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Clr_Ld = 1'b0, Add = 1'b0, Sub = 1'b0, Shift = 1'b0;
  logic [7:0] S = 8'h00;
  logic [7:0] Aval, Bval;
  logic       X, M, Done, Err;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] CLR = 4'b1000;
  localparam logic [3:0] ADD = 4'b0100;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] SHF = 4'b0001;

  int n_chk = 0;
  int n_pass = 0;

  int mA, mB, mX, mstep, mdone, merr;

  multiplier_datapath dut (
    .Clk(Clk), .Reset(Reset), .Clr_Ld(Clr_Ld), .Add(Add), .Sub(Sub), .Shift(Shift),
    .S(S), .Aval(Aval), .Bval(Bval), .X(X), .M(M), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mA = 0; mB = 0; mX = 0; mstep = 0; mdone = 0; merr = 0;
  endtask

  // Behavioural rules: product chain as a 17-bit integer, add/sub as signed ints.
  task automatic model_op(input logic [3:0] st, input logic [7:0] sv);
    int n, a_s, s_s, r, chain;
    n = $countones(st);
    s_s = $signed(sv);
    a_s = (mA >= 128) ? mA - 256 : mA;
    if (n > 1) merr = 1;
    else if (st == CLR) begin
      mA = 0; mX = 0; mB = int'(sv); mstep = 0; mdone = 0; merr = 0;
    end else if (n == 1 && mdone == 1) merr = 1;
    else if (st == ADD || st == SUB) begin
      r = (st == ADD) ? a_s + s_s : a_s - s_s;
      r = r & 511;
      mA = r & 255;
      mX = r >> 8;
    end else if (st == SHF) begin
      chain = (mX << 16) | (mA << 8) | mB;
      chain = (chain >> 1) | (mX << 16);
      mA = (chain >> 8) & 255;
      mB = chain & 255;
      mstep++;
      if (mstep == 8) mdone = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".A"}, 32'(Aval), mA);
    chk({tag, ".B"}, 32'(Bval), mB);
    chk({tag, ".X"}, 32'(X), mX);
    chk({tag, ".M"}, 32'(M), mB & 1);
    chk({tag, ".Done"}, 32'(Done), mdone);
    chk({tag, ".Err"}, 32'(Err), merr);
  endtask

  task automatic cyc(input string tag, input logic [3:0] st, input logic [7:0] sv);
    @(negedge Clk);
    {Clr_Ld, Add, Sub, Shift} = st;
    S = sv;
    @(posedge Clk);
    model_op(st, sv);
    #1;
    {Clr_Ld, Add, Sub, Shift} = NOP;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic [3:0] st);
    @(negedge Clk);
    Reset = 1'b1;
    {Clr_Ld, Add, Sub, Shift} = st;
    S = 8'($urandom);
    @(posedge Clk);
    model_reset();
    #1;
    Reset = 1'b0;
    {Clr_Ld, Add, Sub, Shift} = NOP;
    check_all(tag);
  endtask

  // Standard control sequence: 7x (Add if M, Shift), then (Sub if M, Shift).
  task automatic run_mult(input string tag, input logic [7:0] mplier, input logic [7:0] mcand);
    int p;
    cyc({tag, ".ld"}, CLR, mplier);
    for (int i = 0; i < 8; i++) begin
      if ((mB & 1) == 1) cyc({tag, ".as"}, (i == 7) ? SUB : ADD, mcand);
      cyc({tag, ".sh"}, SHF, 8'($urandom));
    end
    p = $signed(mplier) * $signed(mcand);
    chk({tag, ".prod"}, 32'({Aval, Bval}), p & 32'hFFFF);
    chk({tag, ".xsign"}, 32'(X), (p < 0) ? 1 : 0);
  endtask

  initial begin
    model_reset();
    do_reset("rst0", NOP);

    // Reset mid-sequence, with a strobe asserted in the same cycle
    cyc("mid.ld", CLR, 8'h55);
    cyc("mid.add", ADD, 8'h11);
    do_reset("mid.rst", ADD);

    run_mult("pos", 8'h07, 8'h03);
    chk("pos.A", 32'(Aval), 32'h00);
    chk("pos.B", 32'(Bval), 32'h15);
    run_mult("negm", 8'hFE, 8'h03);
    chk("negm.AB", 32'({Aval, Bval}), 32'hFFFA);
    chk("negm.X", 32'(X), 1);

    // Corner: -128 * -128
    cyc("cor.ld", CLR, 8'h80);
    for (int i = 0; i < 7; i++) cyc("cor.sh", SHF, 8'h80);
    cyc("cor.sub", SUB, 8'h80);
    chk("cor.subA", 32'(Aval), 32'h80);
    chk("cor.subX", 32'(X), 0);
    cyc("cor.sh8", SHF, 8'h80);
    chk("cor.AB", 32'({Aval, Bval}), 32'h4000);

    // Illegal strobes
    cyc("ill.ld", CLR, 8'h55);
    cyc("ill.add", ADD, 8'h11);
    cyc("ill.two", ADD | SHF, 8'h22);
    chk("ill.err", 32'(Err), 1);
    cyc("ill.clr", CLR, 8'h01);
    chk("ill.errclr", 32'(Err), 0);
    for (int i = 0; i < 8; i++) cyc("ill.sh", SHF, 8'h00);
    chk("ill.done", 32'(Done), 1);
    cyc("ill.sh9", SHF, 8'h00);
    chk("ill.err9", 32'(Err), 1);
    cyc("ill.addd", ADD, 8'h05);
    cyc("ill.clr2", CLR, 8'h00);

    // Sub wrap
    cyc("wrap.sub", SUB, 8'h01);
    chk("wrap.A", 32'(Aval), 32'hFF);
    chk("wrap.X", 32'(X), 1);
    cyc("wrap.sh", SHF, 8'h00);
    chk("wrap.A2", 32'(Aval), 32'hFF);
    chk("wrap.B7", 32'(Bval[7]), 1);

    // Randomized full multiplies
    for (int k = 0; k < 40; k++) run_mult("rmul", 8'($urandom), 8'($urandom));

    // Randomized strobe soup including illegal combos and resets
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) do_reset("rnd.rst", 4'($urandom));
      else if (r < 3) cyc("rnd.clr", CLR, 8'($urandom));
      else if (r < 6) cyc("rnd.add", ADD, 8'($urandom));
      else if (r < 8) cyc("rnd.sub", SUB, 8'($urandom));
      else if (r < 14) cyc("rnd.sh", SHF, 8'($urandom));
      else if (r < 16) cyc("rnd.nop", NOP, 8'($urandom));
      else cyc("rnd.any", 4'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
